// File: rtl/mom_bank_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mom_bank_step_ctrl_if
// Brief    : Target handshake and bank-drive bundle for mom_bank_step_ctrl.
//            The master drives target/freeze; the slave (the controller)
//            drives the unit enables and status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface mom_bank_step_ctrl_if #(
  parameter int N_UNITS = 16,
  parameter int CW      = $clog2(N_UNITS + 1)
);
  logic               tgt_valid;
  logic               tgt_ready;
  logic [CW-1:0]      tgt_code;
  logic               freeze;
  logic [N_UNITS-1:0] en_therm;
  logic [CW-1:0]      cur_code;
  logic               busy;
  logic               done;
  logic               sat;

  modport master (
    output tgt_valid, tgt_code, freeze,
    input  tgt_ready, en_therm, cur_code, busy, done, sat
  );

  modport slave (
    input  tgt_valid, tgt_code, freeze,
    output tgt_ready, en_therm, cur_code, busy, done, sat
  );
endinterface
`default_nettype wire

// File: rtl/mom_bank_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mom_bank_step_ctrl
// Brief    : Walks a thermometer-coded MOM1 capacitor bank one unit at a time
//            toward an accepted target, dwelling STEP_DLY cycles per step so
//            the rail never sees a large capacitance step.
// Revision : 1.0 - initial release
// ============================================================================
module mom_bank_step_ctrl #(
  parameter int N_UNITS  = 16,
  parameter int STEP_DLY = 4,
  parameter int CW       = $clog2(N_UNITS + 1)
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mom_bank_step_ctrl_if.slave bus
);

  // Timer holds values 0..STEP_DLY-1; keep at least one bit.
  localparam int            TW    = (STEP_DLY > 1) ? $clog2(STEP_DLY) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(STEP_DLY - 1);
  localparam logic [CW-1:0] MAXC  = CW'(N_UNITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      code_q, code_d;
  logic [CW-1:0]      tgt_q, tgt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sat_q, sat_d;
  logic [N_UNITS-1:0] en_q, en_d;

  logic               accept;
  logic               over;
  logic [CW-1:0]      clamp;

  // Targets above the bank size are clamped to a full bank.
  assign over   = (bus.tgt_code > MAXC);
  assign clamp  = over ? MAXC : bus.tgt_code;
  assign accept = bus.tgt_valid && bus.tgt_ready;

  assign bus.tgt_ready = (state_q == IDLE) && !bus.freeze;
  assign bus.en_therm  = en_q;
  assign bus.cur_code  = code_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sat       = sat_q;

  // Next-state and next-output logic for the stepping sequencer.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    en_d    = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d = clamp;
          sat_d = sat_q | over;
          if (clamp == code_q) begin
            // Nothing to walk: report completion without raising busy.
            state_d = FINISH;
          end else begin
            // First step is applied on the accepting edge.
            state_d = STEP;
            code_d  = (clamp > code_q) ? code_q + CW'(1) : code_q - CW'(1);
            timer_d = TMAX;
            busy_d  = 1'b1;
          end
        end
      end
      STEP: begin
        if (!bus.freeze) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (code_q != tgt_q) begin
            code_d  = (tgt_q > code_q) ? code_q + CW'(1) : code_q - CW'(1);
            timer_d = TMAX;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Thermometer decode of the next code: unit i on iff i < code.
    for (int i = 0; i < N_UNITS; i++) begin
      en_d[i] = (i < int'(code_d));
    end
  end

  // State and registered outputs; reset switches every unit off at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      tgt_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      en_q    <= en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mom_bank_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mom_bank_step_ctrl
// Brief    : Directed bench for mom_bank_step_ctrl. Two instances (16 and 12
//            units) share one stimulus; a schedule-based model predicts every
//            output each cycle, and literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mom_bank_step_ctrl;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [4:0] code5 = '0;
  logic       frz = 1'b0;
  bit         chk_en = 1'b0;

  int passed = 0;
  int total  = 0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  mom_bank_step_ctrl_if #(.N_UNITS(16)) if0 ();
  mom_bank_step_ctrl_if #(.N_UNITS(12)) if1 ();

  assign if0.tgt_valid = valid;
  assign if0.tgt_code  = code5;
  assign if0.freeze    = frz;
  assign if1.tgt_valid = valid;
  assign if1.tgt_code  = code5[3:0];
  assign if1.freeze    = frz;

  mom_bank_step_ctrl #(.N_UNITS(16), .STEP_DLY(SD)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mom_bank_step_ctrl #(.N_UNITS(12), .STEP_DLY(SD)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Model: an accepted walk of distance d lasts d*SD+1 unfrozen busy cycles;
  // the code at unfrozen busy-cycle k is start +/- min(d, k/SD + 1); done
  // follows the last of those cycles. The closing cycle ignores freeze.
  int m_code[2]  = '{0, 0};
  int m_start[2] = '{0, 0};
  int m_d[2]     = '{0, 0};
  int m_k[2]     = '{0, 0};
  bit m_act[2]   = '{0, 0};
  bit m_up[2]    = '{0, 0};
  bit m_busy[2]  = '{0, 0};
  bit m_done[2]  = '{0, 0};
  bit m_sat[2]   = '{0, 0};
  int NU[2]      = '{16, 12};

  // Advance the model on each rising edge with the same inputs the DUTs see.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int c_in, t, st;
      c_in = (i == 0) ? int'(code5) : int'(code5[3:0]);
      if (rst) begin
        m_code[i] = 0; m_act[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_sat[i] = 0;
      end else if (!m_act[i]) begin
        m_done[i] = 0;
        if (valid && !frz) begin
          t = (c_in > NU[i]) ? NU[i] : c_in;
          if (c_in > NU[i]) m_sat[i] = 1;
          m_start[i] = m_code[i];
          m_d[i]     = (t > m_code[i]) ? t - m_code[i] : m_code[i] - t;
          m_up[i]    = (t > m_code[i]);
          m_k[i]     = 0;
          m_act[i]   = 1;
          if (m_d[i] != 0) begin
            m_busy[i] = 1;
            m_code[i] = m_up[i] ? m_start[i] + 1 : m_start[i] - 1;
          end
        end
      end else begin
        m_done[i] = 0;
        if (m_k[i] == m_d[i] * SD) begin
          m_act[i]  = 0;
          m_busy[i] = 0;
          m_done[i] = 1;
        end else begin
          if (!frz) m_k[i]++;
          st = m_k[i] / SD + 1;
          if (st > m_d[i]) st = m_d[i];
          m_code[i] = m_up[i] ? m_start[i] + st : m_start[i] - st;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  task automatic chk_inst(input int i, input longint en, input longint cc, input bit b,
                          input bit d, input bit s, input bit r);
    longint exp_en;
    exp_en = (64'd1 << m_code[i]) - 64'd1;
    chk($sformatf("u%0d_en_therm", i), en, exp_en);
    chk($sformatf("u%0d_cur_code", i), cc, longint'(m_code[i]));
    chk($sformatf("u%0d_busy", i), longint'(b), longint'(m_busy[i]));
    chk($sformatf("u%0d_done", i), longint'(d), longint'(m_done[i]));
    chk($sformatf("u%0d_sat", i), longint'(s), longint'(m_sat[i]));
    chk($sformatf("u%0d_tgt_ready", i), longint'(r), longint'(!m_act[i] && !frz));
  endtask

  // Compare both DUTs against the model every cycle, clear of the clock edge.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk_inst(0, longint'(if0.en_therm), longint'(if0.cur_code), if0.busy, if0.done, if0.sat, if0.tgt_ready);
      chk_inst(1, longint'(if1.en_therm), longint'(if1.cur_code), if1.busy, if1.done, if1.sat, if1.tgt_ready);
      if (if0.done) done_cnt0++;
    end
  end

  // Offer a target for one cycle; returns at the sample point of cycle 1.
  task automatic accept(input logic [4:0] v);
    @(negedge clk); code5 = v; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(if0.tgt_ready && if1.tgt_ready) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) begin
      total++;
      $display("FAIL wait_idle_timeout actual=%0d cycles required=<500", n);
    end
    @(negedge clk);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_cur_code", longint'(if0.cur_code), 0);
    chk("reset_en_therm", longint'(if0.en_therm), 0);
    chk("reset_ready", longint'(if0.tgt_ready), 1);
    chk_en = 1'b1;

    // 0 -> 3: steps at cycles 1,5,9; busy through 13; done at 14.
    accept(5'd3);
    chk("t1_c1_code", longint'(if0.cur_code), 1);
    chk("t1_c1_busy", longint'(if0.busy), 1);
    repeat (4) @(negedge clk);
    chk("t1_c5_code", longint'(if0.cur_code), 2);
    repeat (4) @(negedge clk);
    chk("t1_c9_code", longint'(if0.cur_code), 3);
    repeat (4) @(negedge clk);
    chk("t1_c13_busy", longint'(if0.busy), 1);
    @(negedge clk); #1;
    chk("t1_c14_done", longint'(if0.done), 1);
    chk("t1_c14_busy", longint'(if0.busy), 0);
    chk("t1_c14_ready", longint'(if0.tgt_ready), 1);
    chk("t1_c14_en", longint'(if0.en_therm), 64'h7);
    @(negedge clk);

    // 3 -> 0: 0x3, 0x1, 0x0 at 4-cycle spacing, one done pulse.
    dc = done_cnt0;
    accept(5'd0);
    chk("t2_c1_en", longint'(if0.en_therm), 64'h3);
    repeat (4) @(negedge clk);
    chk("t2_c5_en", longint'(if0.en_therm), 64'h1);
    repeat (4) @(negedge clk);
    chk("t2_c9_en", longint'(if0.en_therm), 64'h0);
    wait_idle();
    chk("t2_done_count", longint'(done_cnt0 - dc), 1);

    // Go to 5, then re-request 5: no walk, busy stays low, done follows.
    accept(5'd5);
    wait_idle();
    accept(5'd5);
    #1;
    chk("t3_c1_busy", longint'(if0.busy), 0);
    chk("t3_c1_code", longint'(if0.cur_code), 5);
    @(negedge clk); #1;
    chk("t3_c2_done", longint'(if0.done), 1);
    chk("t3_c2_en", longint'(if0.en_therm), 64'h1F);
    wait_idle();

    // 15 on the 12-unit bank clamps to 12 and sets a sticky sat.
    accept(5'd15);
    wait_idle();
    chk("t4_u1_code", longint'(if1.cur_code), 12);
    chk("t4_u1_en", longint'(if1.en_therm), 64'hFFF);
    chk("t4_u1_sat", longint'(if1.sat), 1);
    chk("t4_u0_sat", longint'(if0.sat), 0);
    chk("t4_u0_code", longint'(if0.cur_code), 15);
    accept(5'd0);
    wait_idle();
    chk("t4_u1_sat_sticky", longint'(if1.sat), 1);
    chk("t4_u1_code0", longint'(if1.cur_code), 0);

    // 0 -> 8 with a 7-cycle freeze after the second step; a mid-walk
    // request for 2 must be ignored.
    accept(5'd8);
    repeat (4) @(negedge clk);
    chk("t5_c5_code", longint'(if0.cur_code), 2);
    @(negedge clk); frz = 1'b1; #1;
    chk("t5_frozen_ready", longint'(if0.tgt_ready), 0);
    @(negedge clk); code5 = 5'd2; valid = 1'b1; #1;
    chk("t5_busy_ready", longint'(if0.tgt_ready), 0);
    @(negedge clk); valid = 1'b0;
    repeat (5) @(negedge clk);
    frz = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_c15_code", longint'(if0.cur_code), 2);
    @(negedge clk);
    chk("t5_c16_code", longint'(if0.cur_code), 3);
    wait_idle();
    chk("t5_final_u0", longint'(if0.cur_code), 8);
    chk("t5_final_u1", longint'(if1.cur_code), 8);

    // Reset mid-walk (8 -> 0) at code 6 switches everything off at once.
    accept(5'd0);
    repeat (4) @(negedge clk);
    chk("t6_c5_code", longint'(if0.cur_code), 6);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_en", longint'(if0.en_therm), 0);
    chk("t6_code", longint'(if0.cur_code), 0);
    chk("t6_busy", longint'(if0.busy), 0);
    chk("t6_done", longint'(if0.done), 0);
    chk("t6_sat_u1", longint'(if1.sat), 0);
    chk("t6_ready", longint'(if0.tgt_ready), 1);

    // Max code on both banks clamps to full; then walk all units down.
    accept(5'd31);
    wait_idle();
    chk("t7_u0_en_full", longint'(if0.en_therm), 64'hFFFF);
    chk("t7_u0_sat", longint'(if0.sat), 1);
    chk("t7_u1_code", longint'(if1.cur_code), 12);
    accept(5'd0);
    wait_idle();
    chk("t7_u0_code0", longint'(if0.cur_code), 0);
    chk("t7_u0_en0", longint'(if0.en_therm), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
